// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first, idle-high line.
//
// The line is brought into the clock domain by a two-flop synchronizer and
// then framed by a small FSM that finds the middle of the start bit and
// samples each following bit one bit period later.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      serial bit rate in bits/s (CPB = CLK_FREQ/BAUD clocks per bit)
//
// Ports
//   clk_i          system clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   uart_txd_in_i  asynchronous serial input
//   byte_o         last correctly framed byte, held between done pulses
//   done_o         one-cycle pulse, byte_o updated in this cycle
//   busy_o         high whenever a frame is in progress (state not idle)
//   frame_err_o    one-cycle pulse when the stop bit samples low
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       uart_txd_in_i,
   output logic [7:0] byte_o,
   output logic       done_o,
   output logic       busy_o,
   output logic       frame_err_o
);

   localparam int unsigned CPB  = CLK_FREQ / BAUD;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CntW = (CPB > 1) ? $clog2(CPB) : 1;

   localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CPB - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      byte_q, byte_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;

   assign rx_s = sync_q[1];

   // State register: synchronizer resets to idle-high so reset never looks
   // like a falling edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], uart_txd_in_i};
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic. cnt restarts from zero on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = StStart;
            end
         end

         StStart: begin
            // Mid start bit: still low means a real start, high is a glitch.
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = StData;
                  bit_d   = '0;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d          = '0;
               shift_d[bit_q] = rx_s;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

         StStop: begin
            // Sampled mid stop bit; returning to idle here leaves half a bit
            // of margin so a back-to-back start bit is not missed.
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitIdle;
               end
            end
         end

         StWaitIdle: begin
            // A low line here is the tail of a broken frame, not a new start.
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      busy_o      = (state_q != StIdle);
      byte_o      = byte_q;
      done_o      = done_q;
      frame_err_o = ferr_q;
   end

endmodule
